// File: rtl/exmem_pipe.sv
// ---------------------------------------------------------------------------
// exmem_pipe
//   EX->MEM pipeline latch with a small data-cache request sequencer.
//   The entry register captures EX-stage control/data when the hazard unit
//   allows it and the memory stage is not stalled. Flush loads a bubble.
//   A two-state FSM (IDLE/REQ) presents the cache request for the latched
//   entry until dhit, stalling the pipe via mem_stall while it waits.
//   Load results are captured into loaddata on the hit edge.
//
// Ports
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   en         advance enable from the hazard unit
//   flush      load a bubble (overrides en and mem_stall)
//   RegWENi, dRENi, dWENi, halti, MemtoRegi, wseli  EX control inputs
//   aluouti, storei, npci                            EX data inputs
//   dhit, dmemload                                   cache response
//   RegWEN, MemtoReg, wsel, aluout, npc, halt        latched to MEM/WB
//   dREN, dWEN, dmemaddr, dmemstore                  cache request
//   loaddata                                         captured load data
//   mem_stall                                        stall to hazard unit
// ---------------------------------------------------------------------------
module exmem_pipe #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              RegWENi,
    input  logic              dRENi,
    input  logic              dWENi,
    input  logic              halti,
    input  logic [1:0]        MemtoRegi,
    input  logic [REG_W-1:0]  wseli,
    input  logic [WORD_W-1:0] aluouti,
    input  logic [WORD_W-1:0] storei,
    input  logic [WORD_W-1:0] npci,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              RegWEN,
    output logic [1:0]        MemtoReg,
    output logic [REG_W-1:0]  wsel,
    output logic [WORD_W-1:0] aluout,
    output logic [WORD_W-1:0] npc,
    output logic              halt,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] loaddata,
    output logic              mem_stall
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t            state, state_next;

    logic              dren_q;
    logic              dwen_q;
    logic [WORD_W-1:0] store_q;
    logic              load;
    logic              mem_op_in;
    logic              capture;

    assign load      = en & ~mem_stall & ~flush;
    assign mem_op_in = dRENi | dWENi;

    // Write has priority so the cache never sees both strobes together.
    assign dWEN      = (state == REQ) & dwen_q;
    assign dREN      = (state == REQ) & dren_q & ~dwen_q;
    assign mem_stall = (state == REQ) & ~dhit;

    assign dmemaddr  = aluout;
    assign dmemstore = store_q;

    // A flush in REQ aborts the access, so a coincident hit is not captured.
    assign capture   = (state == REQ) & dhit & dREN & ~flush;

    // Entry register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            RegWEN   <= 1'b0;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            MemtoReg <= '0;
            wsel     <= '0;
            aluout   <= '0;
            store_q  <= '0;
            npc      <= '0;
        end else if (flush) begin
            RegWEN   <= 1'b0;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            MemtoReg <= '0;
            wsel     <= '0;
            aluout   <= '0;
            store_q  <= '0;
            npc      <= '0;
        end else if (load) begin
            RegWEN   <= RegWENi;
            dren_q   <= dRENi;
            dwen_q   <= dWENi;
            MemtoReg <= MemtoRegi;
            wsel     <= wseli;
            aluout   <= aluouti;
            store_q  <= storei;
            npc      <= npci;
        end
    end

    // Halt is sticky until reset; a bubble never carries halt.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt <= 1'b0;
        end else if (load && halti) begin
            halt <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            loaddata <= '0;
        end else if (capture) begin
            loaddata <= dmemload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load can only happen in REQ on the hit edge (mem_stall low), so a
    // new memory-op entry keeps the FSM in REQ back-to-back.
    always_comb begin
        state_next = IDLE;
        if (flush) begin
            state_next = IDLE;
        end else if (load && mem_op_in) begin
            state_next = REQ;
        end else if (state == REQ && !dhit) begin
            state_next = REQ;
        end
    end

endmodule

// File: tb/tb_exmem_pipe.sv
// ---------------------------------------------------------------------------
// tb_exmem_pipe
//   Self-checking bench for exmem_pipe. Expected load results are queued as
//   each load is issued and compared when the cache hit completes.
// ---------------------------------------------------------------------------
module tb_exmem_pipe;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              en, flush;
    logic              RegWENi, dRENi, dWENi, halti;
    logic [1:0]        MemtoRegi;
    logic [REG_W-1:0]  wseli;
    logic [WORD_W-1:0] aluouti, storei, npci;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              RegWEN;
    logic [1:0]        MemtoReg;
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-1:0] aluout, npc;
    logic              halt, dREN, dWEN;
    logic [WORD_W-1:0] dmemaddr, dmemstore, loaddata;
    logic              mem_stall;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [WORD_W-1:0] sb[$];
    bit cap_pending = 1'b0;

    always #5 CLK = ~CLK;

    exmem_pipe #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .RegWENi(RegWENi), .dRENi(dRENi), .dWENi(dWENi), .halti(halti),
        .MemtoRegi(MemtoRegi), .wseli(wseli),
        .aluouti(aluouti), .storei(storei), .npci(npci),
        .dhit(dhit), .dmemload(dmemload),
        .RegWEN(RegWEN), .MemtoReg(MemtoReg), .wsel(wsel),
        .aluout(aluout), .npc(npc), .halt(halt),
        .dREN(dREN), .dWEN(dWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .loaddata(loaddata), .mem_stall(mem_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; flush = 1'b0;
        RegWENi = 1'b0; dRENi = 1'b0; dWENi = 1'b0; halti = 1'b0;
        MemtoRegi = '0; wseli = '0;
        aluouti = '0; storei = '0; npci = '0;
        dhit = 1'b0; dmemload = '0;
    endtask

    // Scoreboard: a hit observed on a read request means loaddata must hold
    // the oldest queued value during the following cycle.
    always @(negedge CLK) begin
        if (cap_pending) begin
            if (sb.size() == 0) check("sb_empty", loaddata, 32'hxxxx_xxxx);
            else check("loaddata", loaddata, sb.pop_front());
            cap_pending = 1'b0;
        end
        if (nRST && dREN && dhit && !flush) cap_pending = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        nRST = 1'b0;
        #3;
        check("rst_dREN", {31'd0, dREN}, 0);
        check("rst_dWEN", {31'd0, dWEN}, 0);
        check("rst_stall", {31'd0, mem_stall}, 0);
        check("rst_halt", {31'd0, halt}, 0);
        check("rst_loaddata", loaddata, 0);
        check("rst_aluout", aluout, 0);
        tick(); tick();
        nRST = 1'b1;

        // Load with zero-wait hit
        en = 1'b1; dRENi = 1'b1; aluouti = 32'h100; RegWENi = 1'b1;
        wseli = 5'd3; MemtoRegi = 2'd1; npci = 32'h204;
        sb.push_back(32'hDEADBEEF);
        tick();
        idle_inputs();
        dhit = 1'b1; dmemload = 32'hDEADBEEF;
        @(negedge CLK);
        check("ld0_dREN", {31'd0, dREN}, 1);
        check("ld0_addr", dmemaddr, 32'h100);
        check("ld0_stall", {31'd0, mem_stall}, 0);
        check("ld0_regwen", {31'd0, RegWEN}, 1);
        check("ld0_wsel", {27'd0, wsel}, 3);
        check("ld0_memtoreg", {30'd0, MemtoReg}, 1);
        check("ld0_npc", npc, 32'h204);
        tick();
        dhit = 1'b0;
        @(negedge CLK);
        check("ld0_dREN_off", {31'd0, dREN}, 0);

        // Store with 3 wait cycles; entry held while stalled
        tick();
        en = 1'b1; dWENi = 1'b1; storei = 32'h1234; aluouti = 32'h200;
        tick();
        en = 1'b1; dWENi = 1'b0; aluouti = 32'hBAD; storei = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("st_dWEN_wait", {31'd0, dWEN}, 1);
            check("st_dREN_wait", {31'd0, dREN}, 0);
            check("st_stall", {31'd0, mem_stall}, 1);
            check("st_addr_held", dmemaddr, 32'h200);
            check("st_data", dmemstore, 32'h1234);
            tick();
        end
        dhit = 1'b1;
        @(negedge CLK);
        check("st_dWEN_hit", {31'd0, dWEN}, 1);
        check("st_stall_hit", {31'd0, mem_stall}, 0);
        tick();
        idle_inputs();
        @(negedge CLK);
        check("st_dWEN_done", {31'd0, dWEN}, 0);
        check("st_next_entry", aluout, 32'hBAD);

        // Back-to-back loads with immediate hits
        tick();
        en = 1'b1; dRENi = 1'b1; aluouti = 32'h10;
        sb.push_back(32'h11111111);
        tick();
        en = 1'b1; dRENi = 1'b1; aluouti = 32'h14;
        dhit = 1'b1; dmemload = 32'h11111111;
        sb.push_back(32'h22222222);
        @(negedge CLK);
        check("b2b_dREN0", {31'd0, dREN}, 1);
        check("b2b_addr0", dmemaddr, 32'h10);
        tick();
        en = 1'b0; dRENi = 1'b0; aluouti = '0; dmemload = 32'h22222222;
        @(negedge CLK);
        check("b2b_dREN1", {31'd0, dREN}, 1);
        check("b2b_addr1", dmemaddr, 32'h14);
        tick();
        dhit = 1'b0;
        @(negedge CLK);
        check("b2b_dREN_off", {31'd0, dREN}, 0);

        // Flush overrides en: bubble latched
        tick();
        flush = 1'b1; en = 1'b1; dRENi = 1'b1; RegWENi = 1'b1;
        wseli = 5'd7; aluouti = 32'h300;
        tick();
        idle_inputs();
        @(negedge CLK);
        check("fl_dREN", {31'd0, dREN}, 0);
        check("fl_regwen", {31'd0, RegWEN}, 0);
        check("fl_wsel", {27'd0, wsel}, 0);
        check("fl_aluout", aluout, 0);

        // Flush during a wait aborts the request
        tick();
        en = 1'b1; dRENi = 1'b1; aluouti = 32'h400;
        tick();
        idle_inputs();
        dmemload = 32'h5555AAAA;
        @(negedge CLK);
        check("ab_dREN", {31'd0, dREN}, 1);
        check("ab_stall", {31'd0, mem_stall}, 1);
        tick();
        flush = 1'b1;
        @(negedge CLK);
        check("ab_dREN_wait2", {31'd0, dREN}, 1);
        tick();
        flush = 1'b0;
        @(negedge CLK);
        check("ab_dREN_drop", {31'd0, dREN}, 0);
        check("ab_stall_drop", {31'd0, mem_stall}, 0);
        check("ab_loaddata", loaddata, 32'h22222222);

        // Sticky halt
        tick();
        en = 1'b1; halti = 1'b1;
        tick();
        halti = 1'b0;
        @(negedge CLK);
        check("halt_set", {31'd0, halt}, 1);
        tick(); tick();
        en = 1'b0;
        @(negedge CLK);
        check("halt_sticky", {31'd0, halt}, 1);

        // Reset in the middle of a store wait
        tick();
        en = 1'b1; dWENi = 1'b1; aluouti = 32'h500; storei = 32'hCAFE;
        tick();
        idle_inputs();
        @(negedge CLK);
        check("rs_dWEN_pre", {31'd0, dWEN}, 1);
        #2;
        nRST = 1'b0;
        #1;
        check("rs_dWEN", {31'd0, dWEN}, 0);
        check("rs_halt", {31'd0, halt}, 0);
        check("rs_stall", {31'd0, mem_stall}, 0);
        check("rs_aluout", aluout, 0);
        check("rs_store", dmemstore, 0);
        check("rs_loaddata", loaddata, 0);
        tick();
        nRST = 1'b1;

        // First load after reset
        en = 1'b1; dRENi = 1'b1; aluouti = 32'h600;
        sb.push_back(32'h0000600D);
        tick();
        idle_inputs();
        dhit = 1'b1; dmemload = 32'h0000600D;
        @(negedge CLK);
        check("post_rst_dREN", {31'd0, dREN}, 1);
        check("post_rst_addr", dmemaddr, 32'h600);
        tick();
        dhit = 1'b0;
        tick();
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exmem_pipe.md
EXMEM_PIPE -- requirements
Module: exmem_pipe

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data/address word width.
REQ-002 SHALL have parameter REG_W, default 5, register-select width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  hazard-unit advance enable for the EX->MEM latch.
REQ-006 SHALL have port flush  input  1  insert bubble.
REQ-007 SHALL have ports RegWENi 1, dRENi 1, dWENi 1, halti 1, MemtoRegi 2, all input, EX-stage control.
REQ-008 SHALL have ports wseli  input  REG_W  destination register.
REQ-009 SHALL have ports aluouti, storei, npci, all input, WORD_W, ALU result/address, store data (forwarded busB), next PC.
REQ-010 SHALL have port dhit  input  1  data-cache hit/done.
REQ-011 SHALL have port dmemload  input  WORD_W  cache read data.
REQ-012 SHALL have outputs RegWEN, MemtoReg, wsel, aluout, npc, halt, latched copies to MEM/WB.
REQ-013 SHALL have outputs dREN, dWEN  1, dmemaddr, dmemstore  WORD_W  cache request.
REQ-014 SHALL have outputs loaddata  WORD_W  captured load result, mem_stall  1  to hazard unit.

Function
REQ-015 Entry register SHALL load all *i inputs on a rising edge when en=1, mem_stall=0, flush=0.
REQ-016 flush=1 SHALL, on the edge, load a bubble: RegWEN, dREN/dWEN requests, MemtoReg, wsel, halt-in all 0; data fields don't-care but cleared to 0; flush overrides en and mem_stall.
REQ-017 en=0 or mem_stall=1 (without flush) SHALL hold the entry unchanged.
REQ-018 Request FSM SHALL have states IDLE and REQ.
REQ-019 IDLE->REQ on an edge that loads an entry with dRENi|dWENi=1; otherwise stay IDLE.
REQ-020 In REQ: dREN=latched dRENi, dWEN=latched dWENi; in IDLE both 0; dREN and dWEN never both 1 (dWEN wins, dREN forced 0).
REQ-021 dmemaddr SHALL equal latched aluout; dmemstore SHALL equal latched store data, at all times.
REQ-022 mem_stall SHALL equal (state==REQ) & ~dhit, combinational.
REQ-023 REQ with dhit=1: at the edge, loaddata<=dmemload if dREN, state->IDLE, unless the same edge loads a new memory-op entry (REQ-015), then state stays REQ.
REQ-024 Zero-wait hit (dhit in first REQ cycle) SHALL incur no stall; each wait cycle adds exactly one stall cycle.
REQ-025 flush while in REQ SHALL abort the request: state->IDLE, loaddata unchanged.
REQ-026 halt output SHALL be sticky: set on loading an entry with halti=1, cleared only by reset; while halt=1 further loads of halti are irrelevant, dREN/dWEN still governed by FSM.
REQ-027 Latency: EX inputs visible on outputs one cycle after the loading edge; loaddata valid the cycle after dhit.

Reset
REQ-028 nRST=0 SHALL immediately and asynchronously clear all registered outputs to 0, state to IDLE, dREN=dWEN=mem_stall=0, halt=0.
REQ-029 Reset asserted mid-request SHALL drop dREN/dWEN in the same cycle with no loaddata update.
REQ-030 After nRST rises, first load occurs on the first edge meeting REQ-015.

Verification
REQ-031 Load, zero wait: dRENi=1, aluouti=0x100, en=1; dhit=1 next cycle, dmemload=0xDEADBEEF -> dREN=1 for 1 cycle, dmemaddr=0x100, mem_stall never 1, loaddata=0xDEADBEEF.
REQ-032 Store, 3 wait: dWENi=1, storei=0x1234, dhit low 3 cycles then high -> dWEN=1 for 4 cycles, mem_stall=1 for 3, entry held, dREN=0 throughout.
REQ-033 Back-to-back loads to 0x10/0x14 with immediate hits -> state stays REQ, two consecutive dREN cycles, loaddata updates each cycle.
REQ-034 flush and en both 1 with dRENi=1 -> bubble latched, dREN=0, RegWEN=0; flush during 2-cycle wait -> dREN drops next cycle, loaddata unchanged.
REQ-035 halti=1 latched, then halti=0 entries -> halt stays 1; nRST pulse mid-store wait -> dWEN, halt, outputs 0 asynchronously.
